// File: rtl/pwm_bridge_driver_array.sv
// N-channel half-bridge PWM driver: one shared edge/centre-aligned period counter,
// per-channel shadow duty, break-before-make dead time, per-channel limit and global fault latch.
module pwm_bridge_driver_array #(
  parameter int N_CH  = 3,
  parameter int PWM_W = 8,
  parameter int DT_W  = 4,
  parameter int PRE_W = 3
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [N_CH*PWM_W-1:0]   PWM,
  input  logic [DT_W-1:0]         DEAD_TIME,
  input  logic [PRE_W-1:0]        PRESCALER,
  input  logic                    CENTER_MODE,
  input  logic                    FAULT,
  input  logic [N_CH-1:0]         LIMIT,
  input  logic                    FAULT_CLEAR,
  output logic [N_CH-1:0]         HI_SIDE_FET,
  output logic [N_CH-1:0]         LOW_SIDE_FET,
  output logic                    FAULT_DETECT,
  output logic                    CYCLE,
  output logic [N_CH-1:0]         LIMIT_FLAG
);

  localparam int PRE_CNT_W = (1 << PRE_W) - 1;
  localparam logic [PWM_W-1:0] MAX = '1;

  logic [PRE_CNT_W-1:0]  r_pre;
  logic [PWM_W-1:0]      r_cnt;
  logic                  r_dir_up;
  logic                  r_started;
  logic                  r_center;
  logic [DT_W-1:0]       r_dead;
  logic [N_CH*PWM_W-1:0] r_duty;
  logic                  r_cycle;
  logic [N_CH-1:0]       r_lim_s1;
  logic [N_CH-1:0]       r_lim_s2;
  logic [N_CH-1:0]       r_lim_flag;
  logic                  r_flt_s1;
  logic                  r_flt_s2;
  logic                  r_fault_det;
  logic                  r_hold;
  logic [N_CH-1:0]       r_cmd;
  logic [DT_W-1:0]       r_dt [N_CH];
  logic [N_CH-1:0]       r_hi;
  logic [N_CH-1:0]       r_lo;

  logic [PRE_CNT_W-1:0]  w_pre_mask;
  logic                  w_tick;
  logic [PWM_W-1:0]      w_cnt_next;
  logic                  w_dir_next;
  logic                  w_period_start;
  logic [DT_W-1:0]       w_gap;
  logic                  w_blk;
  logic [N_CH-1:0]       w_cmd;
  logic [N_CH-1:0]       w_on;
  logic [DT_W-1:0]       w_dt_next [N_CH];

  // Low PRESCALER bits of the free-running counter all zero -> tick.
  assign w_pre_mask = ~({PRE_CNT_W{1'b1}} << PRESCALER);
  assign w_tick     = ((r_pre & w_pre_mask) == '0);

  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir_up;
    if (!r_started) begin
      w_cnt_next = '0;
    end else if (!r_center) begin
      w_cnt_next = r_cnt + 1'b1;
    end else if (r_dir_up) begin
      if (r_cnt == MAX) begin
        w_cnt_next = MAX - 1'b1;
        w_dir_next = 1'b0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  assign w_period_start = w_tick && (w_cnt_next == '0);
  assign w_gap          = (r_dead == '0) ? DT_W'(1) : r_dead;
  // Fault kills the gates immediately; the hold keeps them off until a clean period start.
  assign w_blk          = r_flt_s2 | r_hold;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PWM_W-1:0] w_duty;
      logic             w_chg;
      assign w_duty = r_duty[gi*PWM_W +: PWM_W];
      assign w_cmd[gi] = !(r_lim_flag[gi] | r_lim_s2[gi]) &&
                         ((w_duty == MAX) || (r_cnt < w_duty));
      assign w_chg = (w_cmd[gi] != r_cmd[gi]);
      // A command change (re)starts the gap; the side turns on as the count reaches 1.
      assign w_on[gi] = !w_chg && (r_dt[gi] <= DT_W'(1));
      assign w_dt_next[gi] = w_chg ? w_gap :
                             ((r_dt[gi] != '0) ? r_dt[gi] - 1'b1 : r_dt[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_pre       <= '0;
      r_cnt       <= '0;
      r_dir_up    <= 1'b1;
      r_started   <= 1'b0;
      r_center    <= 1'b0;
      r_dead      <= '0;
      r_duty      <= '0;
      r_cycle     <= 1'b0;
      r_lim_s1    <= '0;
      r_lim_s2    <= '0;
      r_lim_flag  <= '0;
      r_flt_s1    <= 1'b0;
      r_flt_s2    <= 1'b0;
      r_fault_det <= 1'b0;
      r_hold      <= 1'b0;
      r_cmd       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      for (int i = 0; i < N_CH; i++) r_dt[i] <= '0;
    end else begin
      r_pre    <= r_pre + 1'b1;
      r_cycle  <= w_period_start;
      r_lim_s1 <= LIMIT;
      r_lim_s2 <= r_lim_s1;
      r_flt_s1 <= FAULT;
      r_flt_s2 <= r_flt_s1;
      if (w_tick) begin
        r_cnt     <= w_cnt_next;
        r_dir_up  <= w_period_start | w_dir_next;
        r_started <= 1'b1;
      end
      if (w_period_start) begin
        r_duty   <= PWM;
        r_dead   <= DEAD_TIME;
        r_center <= CENTER_MODE;
      end
      r_lim_flag <= w_period_start ? '0 : (r_lim_flag | r_lim_s2);
      if (r_flt_s2) begin
        r_fault_det <= 1'b1;
      end else if (FAULT_CLEAR) begin
        r_fault_det <= 1'b0;
      end
      r_hold <= r_flt_s2 | (r_hold & !(w_period_start & !r_fault_det));
      r_cmd  <= w_cmd;
      r_hi   <= {N_CH{!w_blk}} & w_on & r_cmd;
      r_lo   <= {N_CH{!w_blk}} & w_on & ~r_cmd;
      for (int i = 0; i < N_CH; i++) r_dt[i] <= w_dt_next[i];
    end
  end

  assign HI_SIDE_FET  = r_hi;
  assign LOW_SIDE_FET = r_lo;
  assign FAULT_DETECT = r_fault_det;
  assign CYCLE        = r_cycle;
  assign LIMIT_FLAG   = r_lim_flag;

endmodule

// File: tb/tb_pwm_bridge_driver_array.sv
// Directed bench for pwm_bridge_driver_array: period lengths, pulse widths,
// dead time, limit, fault and asynchronous reset, checked against hand-computed values.
module tb_pwm_bridge_driver_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pwm = '0;
  logic [3:0]  dead = 4'd4;
  logic [2:0]  pre = '0;
  logic        cm = 1'b0;
  logic        fault = 1'b0;
  logic [2:0]  limit = '0;
  logic        fclr = 1'b0;
  logic [2:0]  hi;
  logic [2:0]  lo;
  logic        fd;
  logic        cyc;
  logic [2:0]  flag;

  int n_chk = 0;
  int n_pass = 0;
  int hi_cnt [3];
  int lo_cnt [3];
  int ovl_cnt;
  int win_len;

  always #5 clk = ~clk;

  pwm_bridge_driver_array dut (
    .CLK          (clk),
    .RESET_n      (rst_n),
    .PWM          (pwm),
    .DEAD_TIME    (dead),
    .PRESCALER    (pre),
    .CENTER_MODE  (cm),
    .FAULT        (fault),
    .LIMIT        (limit),
    .FAULT_CLEAR  (fclr),
    .HI_SIDE_FET  (hi),
    .LOW_SIDE_FET (lo),
    .FAULT_DETECT (fd),
    .CYCLE        (cyc),
    .LIMIT_FLAG   (flag)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycle(input string tag);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (!cyc && k < 3000);
    check(tag, int'(cyc), 1);
  endtask

  // Starts on a CYCLE sample and accumulates until the next CYCLE sample.
  task automatic measure();
    for (int i = 0; i < 3; i++) begin
      hi_cnt[i] = 0;
      lo_cnt[i] = 0;
    end
    ovl_cnt = 0;
    win_len = 0;
    do begin
      for (int i = 0; i < 3; i++) begin
        hi_cnt[i] += int'(hi[i]);
        lo_cnt[i] += int'(lo[i]);
        if (hi[i] && lo[i]) ovl_cnt++;
      end
      win_len++;
      step(1);
    end while (!cyc && win_len < 3000);
  endtask

  initial begin
    int active;
    int k;

    // Reset state
    step(3);
    check("reset_outputs", int'({hi, lo, fd, cyc, flag}), 0);

    // Test 1: edge mode, duties 64/128/192, dead time 4
    pwm = {8'd192, 8'd128, 8'd64};
    rst_n = 1'b1;
    step(1);
    check("t1_first_tick_cycle", int'(cyc), 1);
    wait_cycle("t1_sync_cycle");
    measure();
    $display("t1 edge: len=%0d hi=%0d/%0d/%0d lo=%0d/%0d/%0d ovl=%0d", win_len,
             hi_cnt[0], hi_cnt[1], hi_cnt[2], lo_cnt[0], lo_cnt[1], lo_cnt[2], ovl_cnt);
    check("t1_period", win_len, 256);
    check("t1_hi0", hi_cnt[0], 60);
    check("t1_hi1", hi_cnt[1], 124);
    check("t1_hi2", hi_cnt[2], 188);
    check("t1_lo0", lo_cnt[0], 188);
    check("t1_lo1", lo_cnt[1], 124);
    check("t1_lo2", lo_cnt[2], 60);
    check("t1_overlap", ovl_cnt, 0);

    // Test 3: duty 0 and MAX stay constant with no gaps
    pwm = {8'd128, 8'd255, 8'd0};
    wait_cycle("t3_latch_cycle");
    wait_cycle("t3_sync_cycle");
    measure();
    $display("t3 extremes: len=%0d lo0=%0d hi0=%0d hi1=%0d lo1=%0d", win_len,
             lo_cnt[0], hi_cnt[0], hi_cnt[1], lo_cnt[1]);
    check("t3_lo0_const", lo_cnt[0], 256);
    check("t3_hi0_none", hi_cnt[0], 0);
    check("t3_hi1_const", hi_cnt[1], 256);
    check("t3_lo1_none", lo_cnt[1], 0);

    // Test 2: centre mode, duty 128, prescaler 1
    cm = 1'b1;
    pre = 3'd1;
    pwm = {8'd128, 8'd128, 8'd128};
    wait_cycle("t2_latch_cycle");
    wait_cycle("t2_sync_cycle");
    check("t2_hi_at_cycle", int'(hi), 7);
    measure();
    $display("t2 centre: len=%0d hi0=%0d lo0=%0d hi2=%0d ovl=%0d", win_len,
             hi_cnt[0], lo_cnt[0], hi_cnt[2], ovl_cnt);
    check("t2_period", win_len, 1020);
    check("t2_hi0", hi_cnt[0], 506);
    check("t2_lo0", lo_cnt[0], 506);
    check("t2_hi2", hi_cnt[2], 506);
    check("t2_overlap", ovl_cnt, 0);

    // Test 4: LIMIT[1] pulse at CNT=50
    cm = 1'b0;
    pre = 3'd0;
    wait_cycle("t4_latch_cycle");
    wait_cycle("t4_sync_cycle");
    step(50);
    check("t4_flag_before", int'(flag), 0);
    limit = 3'b010;
    step(1);
    limit = 3'b000;
    step(1);
    check("t4_hi1_before_drop", int'(hi[1]), 1);
    step(1);
    $display("t4 limit: hi=%b lo=%b flag=%b", hi, lo, flag);
    check("t4_hi1_dropped", int'(hi[1]), 0);
    check("t4_lo1_gap", int'(lo[1]), 0);
    check("t4_flag_set", int'(flag), 2);
    step(3);
    check("t4_lo1_still_gap", int'(lo[1]), 0);
    step(1);
    check("t4_lo1_on", int'(lo[1]), 1);
    check("t4_others_hi", int'({hi[2], hi[0]}), 3);
    step(198);
    check("t4_flag_held", int'(flag), 2);
    step(1);
    check("t4_cycle", int'(cyc), 1);
    check("t4_flag_cleared", int'(flag), 0);
    step(10);
    check("t4_hi1_resumed", int'(hi), 7);

    // Test 5: fault latch and re-arm
    fault = 1'b1;
    step(3);
    $display("t5 fault: hi=%b lo=%b fd=%b", hi, lo, fd);
    check("t5_outputs_off", int'({hi, lo}), 0);
    check("t5_detect", int'(fd), 1);
    fclr = 1'b1;
    step(1);
    fclr = 1'b0;
    step(2);
    check("t5_clear_ignored", int'(fd), 1);
    fault = 1'b0;
    step(4);
    fclr = 1'b1;
    step(1);
    fclr = 1'b0;
    check("t5_cleared", int'(fd), 0);
    active = 0;
    k = 0;
    while (!cyc && k < 600) begin
      if ({hi, lo} != 6'd0) active++;
      step(1);
      k++;
    end
    check("t5_next_cycle", int'(cyc), 1);
    check("t5_held_off", active, 0);
    check("t5_off_at_cycle", int'({hi, lo}), 0);
    step(10);
    check("t5_resumed", int'(hi), 7);

    // Test 6: asynchronous reset mid-period with HI active
    step(10);
    check("t6_hi_before_reset", int'(hi), 7);
    #2;
    rst_n = 1'b0;
    #1;
    $display("t6 reset: hi=%b lo=%b fd=%b cyc=%b flag=%b", hi, lo, fd, cyc, flag);
    check("t6_async_reset", int'({hi, lo, fd, cyc, flag}), 0);
    #2;
    rst_n = 1'b1;
    step(1);
    check("t6_first_tick_cycle", int'(cyc), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
